// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: March C- (reduced) BIST initiator driving a two-port RAM and checking its read data
module ram_bist_ctrl #(
  parameter int Width       = 32,
  parameter int Depth       = 256,
  parameter int ReadLatency = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       fail_o,
  output logic [$clog2(Depth)-1:0]   err_addr_o,
  output logic [Width-1:0]           err_data_o,
  output logic                       we_o,
  output logic [$clog2(Depth)-1:0]   waddr_o,
  output logic [Width-1:0]           wdata_o,
  output logic                       re_o,
  output logic [$clog2(Depth)-1:0]   raddr_o,
  input  logic [Width-1:0]           rdata_i
);
  localparam int Aw = $clog2(Depth);
  localparam logic [Aw-1:0] Last = Aw'(Depth - 1);
  typedef enum logic [3:0] {IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [Aw-1:0] addr_q, addr_d;
  logic [2:0] cnt_q, cnt_d;
  logic at_last, at_first, launch, mism;
  logic [ReadLatency-1:0] pv_q, pe_q;
  logic [ReadLatency-1:0][Aw-1:0] pa_q;
  assign at_last  = addr_q == Last;
  assign at_first = addr_q == '0;
  assign launch   = start_i && (state_q == IDLE || state_q == DONE);
  assign mism     = pv_q[ReadLatency-1] && rdata_i != {Width{pe_q[ReadLatency-1]}};
  // state, address counter and drain counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end
  // march sequencing: R->W on the same cell, terminal-address compare ends each element
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = '0;
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = M0_W;
        addr_d  = '0;
      end
      M0_W: begin
        state_d = at_last ? M1_R : M0_W;
        addr_d  = at_last ? '0 : addr_q + 1'b1;
      end
      M1_R: state_d = M1_W;
      M1_W: begin
        state_d = at_last ? M2_R : M1_R;
        addr_d  = at_last ? Last : addr_q + 1'b1;
      end
      M2_R: state_d = M2_W;
      M2_W: begin
        state_d = at_first ? M3_R : M2_R;
        addr_d  = at_first ? Last : addr_q - 1'b1;
      end
      M3_R: begin
        state_d = at_first ? DRAIN : M3_R;
        addr_d  = at_first ? '0 : addr_q - 1'b1;
      end
      DRAIN: begin
        state_d = cnt_q == 3'(ReadLatency - 1) ? DONE : DRAIN;
        cnt_d   = cnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // RAM-side and status outputs decoded from registered state and address
  always_comb begin
    we_o    = state_q inside {M0_W, M1_W, M2_W};
    re_o    = state_q inside {M1_R, M2_R, M3_R};
    waddr_o = we_o ? addr_q : '0;
    raddr_o = re_o ? addr_q : '0;
    wdata_o = {Width{state_q == M1_W}};
    busy_o  = state_q != IDLE && state_q != DONE;
    done_o  = state_q == DONE;
    pass_o  = done_o & ~fail_o;
  end
  // compare pipeline: each read carries its expected background and address until data returns
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      pe_q <= '0;
      pa_q <= '0;
    end else begin
      pv_q[0] <= re_o;
      pe_q[0] <= state_q == M2_R;
      pa_q[0] <= addr_q;
      for (int i = 1; i < ReadLatency; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
    end
  end
  // sticky fail flag holding only the first mismatch; a new run clears it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_o     <= 1'b0;
      err_addr_o <= '0;
      err_data_o <= '0;
    end else if (launch) begin
      fail_o     <= 1'b0;
      err_addr_o <= '0;
      err_data_o <= '0;
    end else if (mism && !fail_o) begin
      fail_o     <= 1'b1;
      err_addr_o <= pa_q[ReadLatency-1];
      err_data_o <= rdata_i;
    end
  end
endmodule
